// File: rtl/core_mem_arbiter.sv
// ============================================================================
// core_mem_arbiter
//
// Purpose
//   Round-robin arbiter that shares one single-port synchronous data memory
//   between up to N_CORES processing cores. One core is served at a time.
//   Write accesses take 2 cycles (IDLE, ACCESS) and read accesses take 3
//   cycles (IDLE, ACCESS, RDATA). Read data returns on a broadcast bus, and a
//   one-hot per-core valid pulse marks which core the data belongs to. Cores
//   whose index is at or above the active core count (n_cores) are masked out.
//
// Parameters
//   N_CORES : number of physical core request ports (1..15)
//   ADDR_W  : memory address width
//   DATA_W  : memory data width
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous, active-high reset
//   n_cores      in   active core count, clamped to N_CORES, 0 = no grants
//   core_req     in   per-core level request
//   core_wr_en   in   per-core direction, 1 = write, 0 = read
//   core_addr    in   per-core address, core i at [i*ADDR_W +: ADDR_W]
//   core_wdata   in   per-core write data, core i at [i*DATA_W +: DATA_W]
//   core_gnt     out  one-hot, 1-cycle pulse, request accepted (ACCESS cycle)
//   core_rvalid  out  one-hot, 1-cycle pulse, core_rdata belongs to that core
//   core_rdata   out  broadcast read data, registered
//   mem_addr     out  memory address (holds its value outside ACCESS)
//   mem_wr_en    out  memory write strobe, high only in a write ACCESS cycle
//   mem_wdata    out  memory write data (holds its value outside ACCESS)
//   mem_rdata    in   memory read data, valid 1 cycle after mem_addr
//   busy         out  high whenever the arbiter is not in IDLE
// ============================================================================
module core_mem_arbiter #(
    parameter int N_CORES = 8,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  n_cores,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES-1:0]          core_wr_en,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    input  logic [N_CORES*DATA_W-1:0]   core_wdata,
    output logic [N_CORES-1:0]          core_gnt,
    output logic [N_CORES-1:0]          core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_wr_en,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    // Core indices fit in 4 bits because N_CORES is at most 15.
    localparam int IW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDATA  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_last;
    logic [IW-1:0]          r_win;
    logic                   r_wr;
    logic [N_CORES-1:0]     r_gnt;
    logic [N_CORES-1:0]     r_rvalid;
    logic [DATA_W-1:0]      r_rdata;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic                   r_mem_wr_en;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic                   r_busy;

    logic [IW-1:0]          w_ncl;
    logic [N_CORES-1:0]     w_mask;
    logic [N_CORES-1:0]     w_active;
    logic                   w_found;
    logic [IW-1:0]          w_win;
    logic [N_CORES-1:0]     w_win_oh;
    logic [N_CORES-1:0]     w_last_win_oh;
    logic                   w_sel_wr;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;

    // ------------------------------------------------------------------
    // Request masking: only cores below min(n_cores, N_CORES) take part.
    // ------------------------------------------------------------------
    always_comb begin
        w_ncl = n_cores;
        if (int'(n_cores) > N_CORES) begin
            w_ncl = IW'(N_CORES);
        end
        w_mask   = N_CORES'((32'd1 << w_ncl) - 32'd1);
        w_active = core_req & w_mask;
    end

    // ------------------------------------------------------------------
    // Round-robin search starting just after the last granted core and
    // wrapping modulo N_CORES; the first active core found wins.
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 1; k <= N_CORES; k++) begin
            idx = int'(r_last) + k;
            if (idx >= N_CORES) begin
                idx = idx - N_CORES;
            end
            if (!w_found && ((w_active & (N_CORES'(1) << idx)) != '0)) begin
                w_found = 1'b1;
                w_win   = IW'(idx);
            end
        end
    end

    // Winner's request fields, selected by shifting the packed buses down.
    always_comb begin
        w_win_oh      = N_CORES'(1) << w_win;
        w_last_win_oh = N_CORES'(1) << r_win;
        w_sel_wr      = |(core_wr_en & w_win_oh);
        w_sel_addr    = ADDR_W'(core_addr >> (int'(w_win) * ADDR_W));
        w_sel_wdata   = DATA_W'(core_wdata >> (int'(w_win) * DATA_W));
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. Outputs are loaded on the edge
    // that enters a state, so core_gnt / mem_* are visible during ACCESS
    // and core_rvalid during the IDLE cycle that follows RDATA.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last      <= IW'(N_CORES - 1);
            r_win       <= '0;
            r_wr        <= 1'b0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wr_en <= 1'b0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            // Pulse outputs default low; they are re-asserted only where needed.
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_mem_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_win       <= w_win;
                        r_last      <= w_win;
                        r_wr        <= w_sel_wr;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_wr_en <= w_sel_wr;
                        r_gnt       <= w_win_oh;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_wr) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_busy  <= 1'b1;
                        r_state <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    // The RAM presents data for the ACCESS address in this cycle.
                    r_rdata  <= mem_rdata;
                    r_rvalid <= w_last_win_oh;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_gnt    = r_gnt;
    assign core_rvalid = r_rvalid;
    assign core_rdata  = r_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    // Reset cancels an in-flight write in the same cycle it is raised.
    assign mem_wr_en   = r_mem_wr_en & ~rst;
    assign busy        = r_busy;

endmodule
